// File: rtl/pp_fetch.sv
// Instruction-fetch stage with IF/ID register for the 5-stage MIPS pipeline.
// Holds the PC, redirects on MEM-stage branches and ID-stage jumps, and stalls on load-use hazards.
module pp_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  JUMP_OPCODE = 6'b000010
) (
    input  logic        clk,
    input  logic        rstb,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        mem_rd_en_ex,
    input  logic [4:0]  rt_ex,
    output logic [31:0] instr_id,
    output logic [31:0] pc_plus4_id,
    output logic        clear_ctrl,
    output logic        stall
);
    logic [31:0] pc;
    logic [31:0] pc_next4;
    logic [31:0] jump_target;
    logic [5:0]  op_id;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        use_rs;
    logic        use_rt;
    logic        hazard;
    logic        jump_id;

    assign imem_addr   = pc;
    assign pc_next4    = pc + 32'd4;
    assign op_id       = instr_id[31:26];
    assign rs_id       = instr_id[25:21];
    assign rt_id       = instr_id[20:16];
    assign jump_id     = (op_id == JUMP_OPCODE) && (instr_id != 32'd0);
    assign jump_target = {pc_plus4_id[31:28], instr_id[25:0], 2'b00};

    // An all-zero IF/ID word is a bubble and must never read a register.
    assign use_rs = (instr_id != 32'd0) && (op_id != JUMP_OPCODE);

    always_comb begin
        case (op_id)
            6'b000000, 6'b000100, 6'b000101, 6'b101011: use_rt = 1'b1;
            default:                                    use_rt = 1'b0;
        endcase
    end

    assign hazard = mem_rd_en_ex && (rt_ex != 5'd0) &&
                    ((use_rs && (rs_id == rt_ex)) || (use_rt && (rt_id == rt_ex)));

    // A taken branch flushes the dependent instruction anyway, so it suppresses the stall.
    assign stall      = hazard && !branch;
    assign clear_ctrl = stall;

    always_ff @(posedge clk) begin
        if (rstb) begin
            pc          <= RESET_PC;
            instr_id    <= 32'd0;
            pc_plus4_id <= 32'd0;
        end else if (branch) begin
            pc          <= branch_target;
            instr_id    <= 32'd0;
            pc_plus4_id <= 32'd0;
        end else if (stall) begin
            pc          <= pc;
            instr_id    <= instr_id;
            pc_plus4_id <= pc_plus4_id;
        end else if (jump_id) begin
            pc          <= jump_target;
            instr_id    <= 32'd0;
            pc_plus4_id <= 32'd0;
        end else begin
            pc          <= pc_next4;
            instr_id    <= imem_data;
            pc_plus4_id <= pc_next4;
        end
    end
endmodule

// File: tb/tb_pp_fetch.sv
// Directed bench for pp_fetch: a fetch-stage model checked every cycle plus literal spot checks.
module tb_pp_fetch;
    logic        clk;
    logic        rstb;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        branch;
    logic [31:0] branch_target;
    logic        mem_rd_en_ex;
    logic [4:0]  rt_ex;
    logic [31:0] instr_id;
    logic [31:0] pc_plus4_id;
    logic        clear_ctrl;
    logic        stall;

    int vectors = 0;
    int errors  = 0;

    localparam logic [31:0] ADD_6_5_7 = 32'h00A7_3020;  // add $6,$5,$7
    localparam logic [31:0] SW_9_2    = 32'hAC49_0000;  // sw  $9,0($2)
    localparam logic [31:0] J_40      = 32'h0800_0010;  // j   0x40
    localparam logic [31:0] J_200     = 32'h0800_0080;  // j   0x200

    pp_fetch dut (
        .clk          (clk),
        .rstb         (rstb),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .branch       (branch),
        .branch_target(branch_target),
        .mem_rd_en_ex (mem_rd_en_ex),
        .rt_ex        (rt_ex),
        .instr_id     (instr_id),
        .pc_plus4_id  (pc_plus4_id),
        .clear_ctrl   (clear_ctrl),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: a few real instructions, otherwise an address-tagged word (opcode 111000).
    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        case (a)
            32'h0000_000C: return ADD_6_5_7;
            32'h0000_0018: return SW_9_2;
            32'h0000_0020: return J_40;
            32'h0000_0044: return ADD_6_5_7;
            32'h0000_0104: return J_200;
            default:       return {4'hE, a[27:0]};
        endcase
    endfunction

    assign imem_data = imem_fn(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the fetch stage must hold, derived from the pipeline rules.
    logic [31:0] m_pc, m_ir, m_p4;
    logic        m_valid = 1'b0;

    function automatic logic m_hazard(input logic [31:0] ir, input logic ld, input logic [4:0] rt);
        logic [5:0] op;
        logic       reads_rs, reads_rt;
        op       = ir[31:26];
        reads_rs = (ir != 0) && (op != 6'b000010);
        reads_rt = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) || (op == 6'b101011);
        return ld && (rt != 0) && ((reads_rs && ir[25:21] == rt) || (reads_rt && ir[20:16] == rt));
    endfunction

    always @(posedge clk) begin
        logic stl;
        stl = m_hazard(m_ir, mem_rd_en_ex, rt_ex) && !branch;
        if (rstb) begin
            m_pc = 32'h0; m_ir = 0; m_p4 = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (branch) begin
                m_pc = branch_target; m_ir = 0; m_p4 = 0;
            end else if (stl) begin
                // hold
            end else if (m_ir[31:26] == 6'b000010 && m_ir != 0) begin
                m_pc = {m_p4[31:28], m_ir[25:0], 2'b00}; m_ir = 0; m_p4 = 0;
            end else begin
                m_ir = imem_fn(m_pc); m_p4 = m_pc + 4; m_pc = m_pc + 4;
            end
        end
    end

    always @(negedge clk) begin
        logic es;
        if (m_valid) begin
            es = m_hazard(m_ir, mem_rd_en_ex, rt_ex) && !branch;
            chk("model_imem_addr", imem_addr, m_pc);
            chk("model_instr_id", instr_id, m_ir);
            chk("model_pc_plus4_id", pc_plus4_id, m_p4);
            chk("model_stall", {31'd0, stall}, {31'd0, es});
            chk("model_clear_ctrl", {31'd0, clear_ctrl}, {31'd0, es});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstb = 1'b1; branch = 1'b0; branch_target = 32'h0; mem_rd_en_ex = 1'b0; rt_ex = 5'd0;
        tick(); tick();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr_id, 32'h0);
        chk("rst_clear", {31'd0, clear_ctrl}, 32'h0);
        rstb = 1'b0;
        tick();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_instr0", instr_id, 32'hE000_0000);
        chk("seq_p4_4", pc_plus4_id, 32'h4);
        tick();
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_instr4", instr_id, 32'hE000_0004);
        tick();
        chk("seq_addrC", imem_addr, 32'hC);
        tick();
        chk("lu_instr_add", instr_id, ADD_6_5_7);
        // Load-use on rs
        mem_rd_en_ex = 1'b1; rt_ex = 5'd5; #1;
        chk("lu_stall", {31'd0, stall}, 32'h1);
        chk("lu_clear", {31'd0, clear_ctrl}, 32'h1);
        tick();
        chk("lu_hold_addr", imem_addr, 32'h10);
        chk("lu_hold_instr", instr_id, ADD_6_5_7);
        mem_rd_en_ex = 1'b0; #1;
        chk("lu_release", {31'd0, stall}, 32'h0);
        tick();
        chk("lu_adv_addr", imem_addr, 32'h14);
        chk("lu_adv_instr", instr_id, 32'hE000_0010);
        // rt_ex=0 never stalls even though rs field is 0
        mem_rd_en_ex = 1'b1; rt_ex = 5'd0; #1;
        chk("rt0_nostall", {31'd0, stall}, 32'h0);
        tick();
        mem_rd_en_ex = 1'b0;
        chk("rt0_addr", imem_addr, 32'h18);
        tick();
        chk("sw_instr", instr_id, SW_9_2);
        // Load-use on rt (store data)
        mem_rd_en_ex = 1'b1; rt_ex = 5'd9; #1;
        chk("sw_stall", {31'd0, stall}, 32'h1);
        tick();
        chk("sw_hold_addr", imem_addr, 32'h1C);
        mem_rd_en_ex = 1'b0; rt_ex = 5'd0;
        tick();
        chk("sw_adv_addr", imem_addr, 32'h20);
        tick();
        chk("j_instr", instr_id, J_40);
        chk("j_p4", pc_plus4_id, 32'h24);
        tick();
        chk("j_addr", imem_addr, 32'h40);
        chk("j_bubble", instr_id, 32'h0);
        tick();
        chk("j_after", instr_id, 32'hE000_0040);
        tick();
        chk("br_instr_add", instr_id, ADD_6_5_7);
        // Branch concurrent with a load-use hazard
        mem_rd_en_ex = 1'b1; rt_ex = 5'd5; branch = 1'b1; branch_target = 32'h100; #1;
        chk("br_nostall", {31'd0, stall}, 32'h0);
        tick();
        branch = 1'b0; mem_rd_en_ex = 1'b0; rt_ex = 5'd0;
        chk("br_addr", imem_addr, 32'h100);
        chk("br_flush", instr_id, 32'h0);
        tick();
        chk("br_target_instr", instr_id, 32'hE000_0100);
        tick();
        chk("bj_instr", instr_id, J_200);
        // Branch beats a jump in ID; target low bits pass through
        branch = 1'b1; branch_target = 32'h302;
        tick();
        branch = 1'b0;
        chk("bj_addr", imem_addr, 32'h302);
        chk("bj_flush", instr_id, 32'h0);
        tick();
        chk("bj_next", imem_addr, 32'h306);
        // PC wrap
        branch = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch = 1'b0;
        chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_instr", instr_id, 32'hEFFF_FFFC);
        chk("wrap_p4", pc_plus4_id, 32'h0);
        tick(); tick(); tick(); tick();
        chk("rs_instr_add", instr_id, ADD_6_5_7);
        // Reset during an active stall
        mem_rd_en_ex = 1'b1; rt_ex = 5'd5; rstb = 1'b1; #1;
        chk("rs_stall", {31'd0, stall}, 32'h1);
        tick();
        chk("rs_addr", imem_addr, 32'h0);
        chk("rs_instr", instr_id, 32'h0);
        chk("rs_clear", {31'd0, clear_ctrl}, 32'h0);
        mem_rd_en_ex = 1'b0; rt_ex = 5'd0;
        tick();
        rstb = 1'b0;
        tick();
        chk("rs_resume", imem_addr, 32'h4);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
